// File: rtl/ffstdp_update_ctrl_if.sv
// Bus between the network controller / synaptic core and the FF-STDP update sequencer.
// The slave modport is the sequencer's view of the bus; the master modport is the controller/core side.
interface ffstdp_update_ctrl_if #(
  parameter int PRE_IDX_WIDTH  = 8,
  parameter int POST_IDX_WIDTH = 8
);
  localparam int AddrWidth = POST_IDX_WIDTH + PRE_IDX_WIDTH;

  logic                      START;
  logic                      TRAIN;
  logic                      PAUSE;
  logic                      BUSY;
  logic                      DONE;
  logic                      SYN_RD_EN;
  logic [AddrWidth-1:0]      SYN_RD_ADDR;
  logic                      CNT_RD_EN;
  logic [PRE_IDX_WIDTH-1:0]  PRE_IDX;
  logic [POST_IDX_WIDTH-1:0] POST_IDX;
  logic                      SYN_WR_EN;
  logic [AddrWidth-1:0]      SYN_WR_ADDR;
  logic                      UPD_TREF_EVENT;
  logic                      UPD_IS_TRAIN;

  modport slave (
    input  START, TRAIN, PAUSE,
    output BUSY, DONE, SYN_RD_EN, SYN_RD_ADDR, CNT_RD_EN, PRE_IDX, POST_IDX,
           SYN_WR_EN, SYN_WR_ADDR, UPD_TREF_EVENT, UPD_IS_TRAIN
  );

  modport master (
    output START, TRAIN, PAUSE,
    input  BUSY, DONE, SYN_RD_EN, SYN_RD_ADDR, CNT_RD_EN, PRE_IDX, POST_IDX,
           SYN_WR_EN, SYN_WR_ADDR, UPD_TREF_EVENT, UPD_IS_TRAIN
  );
endinterface

// File: rtl/ffstdp_update_ctrl.sv
// FF-STDP training-pass sequencer: walks every {post, pre} synapse, issues reads and
// writes each updated weight back two cycles later through a fixed valid/address pipeline.
module ffstdp_update_ctrl #(
  parameter int N_PRE          = 256,
  parameter int N_POST         = 256,
  parameter int PRE_IDX_WIDTH  = 8,
  parameter int POST_IDX_WIDTH = 8
) (
  input logic                CLK,
  input logic                RST,
  ffstdp_update_ctrl_if.slave bus
);
  localparam int AddrWidth = POST_IDX_WIDTH + PRE_IDX_WIDTH;
  localparam logic [PRE_IDX_WIDTH-1:0]  PreLast  = PRE_IDX_WIDTH'(N_PRE - 1);
  localparam logic [POST_IDX_WIDTH-1:0] PostLast = POST_IDX_WIDTH'(N_POST - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                    state, state_nxt;
  logic [PRE_IDX_WIDTH-1:0]  pre_cnt;
  logic [POST_IDX_WIDTH-1:0] post_cnt;
  logic                      is_train;
  logic                      v1, v2;
  logic [AddrWidth-1:0]      a1, a2;
  logic                      rd_en, pre_last, post_last;

  always_comb begin
    rd_en     = (state == RUN) && !bus.PAUSE;
    pre_last  = (pre_cnt == PreLast);
    post_last = (post_cnt == PostLast);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = bus.TRAIN ? RUN : FINISH;
      RUN:     if (rd_en && pre_last && post_last) state_nxt = DRAIN;
      // Stage 1 empty here means stage 2 is empty next cycle, giving N+2 busy cycles.
      DRAIN:   if (!v1) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      post_cnt <= '0;
      is_train <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      a1       <= '0;
      a2       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.START && bus.TRAIN) begin
        pre_cnt  <= '0;
        post_cnt <= '0;
        is_train <= 1'b1;
      end else if (rd_en) begin
        if (pre_last) begin
          pre_cnt  <= '0;
          post_cnt <= post_last ? '0 : post_cnt + 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
      if (state == FINISH) is_train <= 1'b0;
      v1 <= rd_en;
      a1 <= {post_cnt, pre_cnt};
      v2 <= v1;
      a2 <= a1;
    end
  end

  assign bus.BUSY           = (state == RUN) || (state == DRAIN);
  assign bus.DONE           = (state == FINISH);
  assign bus.SYN_RD_EN      = rd_en;
  assign bus.CNT_RD_EN      = rd_en;
  assign bus.SYN_RD_ADDR    = {post_cnt, pre_cnt};
  assign bus.PRE_IDX        = pre_cnt;
  assign bus.POST_IDX       = post_cnt;
  assign bus.SYN_WR_EN      = v2;
  assign bus.SYN_WR_ADDR    = a2;
  assign bus.UPD_TREF_EVENT = v2;
  assign bus.UPD_IS_TRAIN   = is_train;
endmodule

// File: tb/tb_ffstdp_update_ctrl.sv
// Directed, table-driven bench for ffstdp_update_ctrl with N_PRE=4, N_POST=3,
// plus a small weight SRAM / saturating update stage model for the write-back check.
module tb_ffstdp_update_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ffstdp_update_ctrl_if #(.PRE_IDX_WIDTH(2), .POST_IDX_WIDTH(2)) bus ();

  ffstdp_update_ctrl #(
    .N_PRE(4), .N_POST(3), .PRE_IDX_WIDTH(2), .POST_IDX_WIDTH(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic       start, train, pause, rst;
    logic       busy, done, rd_en;
    logic [3:0] rd_addr;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       is_train;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // SRAM + update stage model: data valid k+1, registered at end of k+1, write in k+2.
  logic [7:0] mem [16];
  logic [7:0] rd_q, upd_q;
  logic       model_on;

  function automatic logic [7:0] sat_add(logic [7:0] w, int d);
    int s;
    s = int'($signed(w)) + d;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return 8'(s);
  endfunction

  always @(posedge clk) begin
    if (model_on) begin
      if (bus.SYN_RD_EN) rd_q <= mem[bus.SYN_RD_ADDR];
      upd_q <= sat_add(rd_q, 5);
      if (bus.UPD_TREF_EVENT && bus.UPD_IS_TRAIN) mem[bus.SYN_WR_ADDR] <= upd_q;
    end
  end

  function automatic vec_t idle_vec();
    vec_t v;
    v.start = 0; v.train = 0; v.pause = 0; v.rst = 0;
    v.busy = 0; v.done = 0; v.rd_en = 0; v.rd_addr = '0;
    v.wr_en = 0; v.wr_addr = '0; v.is_train = 0;
    return v;
  endfunction

  function automatic logic [3:0] enc(int i);
    return 4'(((i / 4) << 2) | (i % 4));
  endfunction

  // Unpaused training pass, local cycle t, START+TRAIN at t=0.
  function automatic vec_t pass_vec(int t);
    vec_t v = idle_vec();
    v.start    = (t == 0);
    v.train    = (t == 0);
    v.rd_en    = (t >= 1 && t <= 12);
    v.rd_addr  = v.rd_en ? enc(t - 1) : 4'h0;
    v.wr_en    = (t >= 3 && t <= 14);
    v.wr_addr  = v.wr_en ? enc(t - 3) : 4'h0;
    v.busy     = (t >= 1 && t <= 14);
    v.done     = (t == 15);
    v.is_train = (t >= 1 && t <= 15);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  int a_end;

  initial begin
    vec_t v;
    logic [7:0] want;

    for (int i = 0; i < 16; i++) mem[i] = (i < 12) ? 8'(i) : 8'hA5;
    mem[6]  = 8'h7E;
    mem[11] = 8'h7C;
    rd_q = '0; upd_q = '0;
    model_on = 1'b1;

    // Reset state
    tbl.push_back(idle_vec());
    tbl.push_back(idle_vec());
    // Plain pass
    for (int t = 0; t <= 16; t++) tbl.push_back(pass_vec(t));
    a_end = tbl.size();
    // PAUSE in cycles 4..6
    for (int t = 0; t <= 19; t++) begin
      v = idle_vec();
      v.start = (t == 0); v.train = (t == 0);
      v.pause = (t >= 4 && t <= 6);
      if (t >= 1 && t <= 3) begin v.rd_en = 1; v.rd_addr = enc(t - 1); end
      if (t >= 7 && t <= 15) begin v.rd_en = 1; v.rd_addr = enc(t - 4); end
      if (t >= 3 && t <= 5) begin v.wr_en = 1; v.wr_addr = enc(t - 3); end
      if (t >= 9 && t <= 17) begin v.wr_en = 1; v.wr_addr = enc(t - 6); end
      v.busy = (t >= 1 && t <= 17);
      v.done = (t == 18);
      v.is_train = (t >= 1 && t <= 18);
      tbl.push_back(v);
    end
    // START with TRAIN=0
    for (int t = 0; t <= 2; t++) begin
      v = idle_vec();
      v.start = (t == 0);
      v.done  = (t == 1);
      tbl.push_back(v);
    end
    // Second START mid-pass is ignored
    for (int t = 0; t <= 18; t++) begin
      v = (t <= 16) ? pass_vec(t) : idle_vec();
      if (t == 5) begin v.start = 1; v.train = 1; end
      tbl.push_back(v);
    end
    // RST in cycle 6, restart at cycle 10
    for (int t = 0; t <= 26; t++) begin
      if (t <= 6) v = pass_vec(t);
      else if (t <= 9) v = idle_vec();
      else v = pass_vec(t - 10);
      v.rst = (t == 6);
      tbl.push_back(v);
    end

    rst = 1'b1;
    bus.START = 0; bus.TRAIN = 0; bus.PAUSE = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (i == a_end) begin
        model_on = 1'b0;
        for (int j = 0; j < 16; j++) begin
          if (j == 6 || j == 11) want = 8'h7F;
          else if (j < 12) want = 8'(j + 5);
          else want = 8'hA5;
          if (mem[j] !== want) begin
            miscompares++;
            $display("FAIL mem[%0d]: got %0h want %0h", j, mem[j], want);
          end
        end
      end
      rst = v.rst;
      bus.START = v.start;
      bus.TRAIN = v.train;
      bus.PAUSE = v.pause;
      @(negedge clk);
      vectors++;
      chk("busy", i, 4'(bus.BUSY), 4'(v.busy));
      chk("done", i, 4'(bus.DONE), 4'(v.done));
      chk("syn_rd_en", i, 4'(bus.SYN_RD_EN), 4'(v.rd_en));
      chk("cnt_rd_en", i, 4'(bus.CNT_RD_EN), 4'(v.rd_en));
      chk("syn_wr_en", i, 4'(bus.SYN_WR_EN), 4'(v.wr_en));
      chk("upd_tref_event", i, 4'(bus.UPD_TREF_EVENT), 4'(v.wr_en));
      chk("upd_is_train", i, 4'(bus.UPD_IS_TRAIN), 4'(v.is_train));
      if (v.rd_en) begin
        chk("syn_rd_addr", i, bus.SYN_RD_ADDR, v.rd_addr);
        chk("pre_idx", i, 4'(bus.PRE_IDX), 4'(v.rd_addr[1:0]));
        chk("post_idx", i, 4'(bus.POST_IDX), 4'(v.rd_addr[3:2]));
      end
      if (v.wr_en) chk("syn_wr_addr", i, bus.SYN_WR_ADDR, v.wr_addr);
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ffstdp_update_ctrl.md
# ffstdp_update_ctrl

Sequencer that drives one FF-STDP training pass over the synaptic weight SRAM. On each refractory/training event it walks every (post, pre) synapse address. For each address it issues a weight read and the matching pre/post spike-count reads, and feeds the fixed 2-cycle pipeline of the downstream weight-update stage. It then writes the updated weight back to the same address two cycles later. It sits between the network controller and the synaptic core: the controller starts it, and it drives the SRAM ports plus the update stage's CTRL_TREF_EVENT/IS_TRAIN inputs.

## Interface
Parameters:
- N_PRE, 256, number of pre-synaptic neurons per row (1..2^PRE_IDX_WIDTH)
- N_POST, 256, number of post-synaptic neurons (1..2^POST_IDX_WIDTH)
- PRE_IDX_WIDTH, 8, pre index width
- POST_IDX_WIDTH, 8, post index width

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse requesting a pass; honoured only in IDLE
- TRAIN  in  1  training enable, sampled with START
- PAUSE  in  1  stalls issue of new reads (arbitration back-pressure)
- BUSY  out  1  pass in progress
- DONE  out  1  one-cycle pulse at end of pass
- SYN_RD_EN  out  1  weight SRAM read enable
- SYN_RD_ADDR  out  POST_IDX_WIDTH+PRE_IDX_WIDTH  read address {post, pre}
- CNT_RD_EN  out  1  spike-count memories read enable (equals SYN_RD_EN)
- PRE_IDX  out  PRE_IDX_WIDTH  pre-count memory address (= SYN_RD_ADDR low field)
- POST_IDX  out  POST_IDX_WIDTH  post-count memory address (= SYN_RD_ADDR high field)
- SYN_WR_EN  out  1  weight SRAM write enable (write-back of update stage output)
- SYN_WR_ADDR  out  POST_IDX_WIDTH+PRE_IDX_WIDTH  write-back address
- UPD_TREF_EVENT  out  1  to update stage CTRL_TREF_EVENT; equals SYN_WR_EN
- UPD_IS_TRAIN  out  1  to update stage IS_TRAIN; latched TRAIN

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE behaviour:
  - START=1 and TRAIN=1: clear pre/post counters, latch UPD_IS_TRAIN=1, go to RUN.
  - START=1 and TRAIN=0: go to FINISH, with no SRAM accesses.
- RUN, when PAUSE=0:
  - Assert SYN_RD_EN/CNT_RD_EN with address {post_cnt, pre_cnt}.
  - Advance pre_cnt. At N_PRE-1, wrap pre_cnt to 0 and advance post_cnt.
  - After issuing address {N_POST-1, N_PRE-1}, go to DRAIN.
- RUN, when PAUSE=1: read enables low, counters hold. PAUSE acts combinationally on SYN_RD_EN in the same cycle.
- Write-back pipeline:
  - A 2-stage valid/address pipeline tracks each issued read.
  - Stage 2 valid drives SYN_WR_EN and UPD_TREF_EVENT; its address drives SYN_WR_ADDR.
  - The pipeline never stalls. PAUSE does not affect in-flight entries.
- DRAIN: wait until both pipeline stages are empty, then go to FINISH.
- FINISH: assert DONE for one cycle, clear UPD_IS_TRAIN, go to IDLE.
- BUSY=1 in RUN and DRAIN only.
- START outside IDLE is ignored. No queuing.
- Order: pre inner loop, post outer loop. Every address is visited exactly once per pass, so there is no read-after-write hazard.

## Timing
- Reset: state=IDLE, counters=0, pipeline valids=0. Every output reads 0, including BUSY, DONE, SYN_RD_EN, CNT_RD_EN, SYN_WR_EN, UPD_TREF_EVENT, UPD_IS_TRAIN, all addresses and indices.
- START sampled at the edge ending cycle 0 → first read in cycle 1.
- Read issued in cycle k:
  - SRAM data and count data are valid in k+1.
  - The update stage registers them at the end of k+1.
  - The write with the same address occurs in cycle k+2.
- Throughput is 1 synapse/cycle without PAUSE. A pass is N_PRE·N_POST+2 cycles of BUSY; DONE follows on the next cycle with BUSY=0.
- PAUSE on the cycle of the final read delays the DRAIN transition. Writes remain exactly 2 cycles after their reads.
- N_PRE=1 or N_POST=1: counters wrap every cycle; the pass is otherwise the same.
- RST mid-pass: takes effect on the next edge. In-flight writes are discarded, with no SYN_WR_EN after the reset edge. No DONE is produced.
- Address outputs may hold stale values when their enable is low. Benches check them only while the enable is high.

## Test plan
- N_PRE=4, N_POST=3, START+TRAIN at cycle 0, PAUSE=0 → required:
  - reads in cycles 1–12 at addresses {0,0},{0,1}…{2,3};
  - writes in cycles 3–14 with the same address sequence;
  - BUSY over cycles 1–14, DONE in cycle 15;
  - UPD_IS_TRAIN=1 over cycles 1–15.
- Same parameters, PAUSE=1 during cycles 4–6 → required:
  - no reads in cycles 4–6; reads resume in cycle 7 at {0,3};
  - writes for the cycle-2 and cycle-3 reads still occur in cycles 4 and 5;
  - DONE in cycle 18.
- START with TRAIN=0 → no SYN_RD_EN/SYN_WR_EN ever; BUSY stays 0; DONE in cycle 1.
- START pulsed again at cycle 5 of an active pass → ignored; exactly 12 writes; a single DONE.
- RST asserted in cycle 6 of a pass → from cycle 7, all outputs 0 and no further writes; a new START at cycle 10 restarts at address {0,0}.
- End to end with the real update stage and SRAM model, weight 0x7E and ROM delta +5 → saturated 0x7F written back to the same address two cycles after its read.
